// File: rtl/issue_group_scoreboard.sv
// In-order issue stage: buffers one fetch group, checks intra-group RAW/WAR/WAW
// and scoreboard RAW/WAW hazards, and releases the longest hazard-free prefix per cycle.
module issue_group_scoreboard #(
    parameter int unsigned REG_W   = 4,
    parameter int unsigned ISSUE_W = 4,
    parameter int unsigned LAT     = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       grp_valid,
    output logic                       grp_ready,
    input  logic [ISSUE_W-1:0]         ins_valid,
    input  logic [ISSUE_W*REG_W-1:0]   des,
    input  logic [ISSUE_W*REG_W-1:0]   src1,
    input  logic [ISSUE_W*REG_W-1:0]   src2,
    input  logic                       flush,
    output logic [ISSUE_W-1:0]         iss_mask,
    output logic [ISSUE_W*REG_W-1:0]   iss_des,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int unsigned NUM_REGS = 2 ** REG_W;
    localparam int unsigned BW       = $clog2(LAT + 1);

    logic                                full_q, full_d;
    logic [ISSUE_W-1:0]                  pending_q, pending_d;
    logic [ISSUE_W-1:0][REG_W-1:0]       des_q, des_d;
    logic [ISSUE_W-1:0][REG_W-1:0]       src1_q, src1_d;
    logic [ISSUE_W-1:0][REG_W-1:0]       src2_q, src2_d;
    logic [NUM_REGS-1:0][BW-1:0]         busy_q, busy_d;
    logic [CNT_W-1:0]                    stall_q, stall_d;

    logic [NUM_REGS-1:0]                 busy;
    logic [ISSUE_W-1:0]                  haz;
    logic [ISSUE_W-1:0]                  iss;
    logic                                blocked;
    logic                                accept;

    always_comb begin : busy_decode
        busy = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy[r] = (busy_q[r] != '0);
        end
    end

    // Slots that issue this cycle still count as earlier-pending for later slots;
    // only slots cleared from pending_q in a previous cycle stop shadowing.
    always_comb begin : hazard_detect
        haz = '0;
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            haz[j] = busy[src1_q[j]] | busy[src2_q[j]] | busy[des_q[j]];
            for (int unsigned i = 0; i < j; i++) begin
                if (pending_q[i] &&
                    ((src1_q[j] == des_q[i]) || (src2_q[j] == des_q[i]) ||
                     (des_q[j] == src1_q[i]) || (des_q[j] == src2_q[i]) ||
                     (des_q[j] == des_q[i]))) begin
                    haz[j] = 1'b1;
                end
            end
        end
    end

    // Non-pending slots are skipped; the first pending slot that cannot go blocks the rest.
    always_comb begin : issue_select
        iss     = '0;
        blocked = 1'b0;
        for (int unsigned j = 0; j < ISSUE_W; j++) begin
            iss[j] = pending_q[j] & ~haz[j] & ~blocked & ~flush & full_q;
            if (pending_q[j] && !iss[j]) begin
                blocked = 1'b1;
            end
        end
    end

    assign iss_mask     = iss;
    assign iss_des      = des_q;
    assign stall_cycles = stall_q;
    assign grp_ready    = ~rst & ~flush & (~full_q | (iss == pending_q));
    assign accept       = grp_valid & grp_ready;

    always_comb begin : buffer_next
        full_d    = full_q;
        pending_d = pending_q;
        des_d     = des_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        if (flush) begin
            full_d    = 1'b0;
            pending_d = '0;
        end else if (accept) begin
            full_d    = |ins_valid;
            pending_d = ins_valid;
            des_d     = des;
            src1_d    = src1;
            src2_d    = src2;
        end else begin
            pending_d = pending_q & ~iss;
            full_d    = |(pending_q & ~iss);
        end
    end

    always_comb begin : scoreboard_next
        busy_d = busy_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (busy_q[r] != '0) begin
                busy_d[r] = busy_q[r] - BW'(1);
            end
            for (int unsigned j = 0; j < ISSUE_W; j++) begin
                if (iss[j] && (des_q[j] == REG_W'(r))) begin
                    busy_d[r] = BW'(LAT);
                end
            end
            if (flush) begin
                busy_d[r] = '0;
            end
        end
    end

    always_comb begin : stall_next
        stall_d = stall_q;
        if (full_q && (iss == '0) && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 1'b0;
            pending_q <= '0;
            des_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            busy_q    <= '0;
            stall_q   <= '0;
        end else begin
            full_q    <= full_d;
            pending_q <= pending_d;
            des_q     <= des_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            busy_q    <= busy_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_issue_group_scoreboard.sv
// Directed bench for issue_group_scoreboard with hand-computed expectations.
module tb_issue_group_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        grp_valid;
    logic        grp_ready;
    logic [3:0]  ins_valid;
    logic [15:0] des, src1, src2;
    logic        flush;
    logic [3:0]  iss_mask;
    logic [15:0] iss_des;
    logic [15:0] stall_cycles;

    int vectors    = 0;
    int miscompares = 0;

    issue_group_scoreboard #(.REG_W(4), .ISSUE_W(4), .LAT(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .grp_valid    (grp_valid),
        .grp_ready    (grp_ready),
        .ins_valid    (ins_valid),
        .des          (des),
        .src1         (src1),
        .src2         (src2),
        .flush        (flush),
        .iss_mask     (iss_mask),
        .iss_des      (iss_des),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input int k, input logic [3:0] d, input logic [3:0] a, input logic [3:0] b);
        des[k*4 +: 4]  = d;
        src1[k*4 +: 4] = a;
        src2[k*4 +: 4] = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; grp_valid = 1'b0; ins_valid = '0; flush = 1'b0;
        des = '0; src1 = '0; src2 = '0;
        #2;
        chk("rst_iss", 32'(iss_mask), 32'h0);
        chk("rst_ready", 32'(grp_ready), 32'h0);
        chk("rst_stall", 32'(stall_cycles), 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(grp_ready), 32'h1);

        // Independent group
        slot(0, 4'd1, 4'd5, 4'd6);  slot(1, 4'd2, 4'd7, 4'd8);
        slot(2, 4'd3, 4'd9, 4'd10); slot(3, 4'd4, 4'd11, 4'd12);
        ins_valid = 4'b1111; grp_valid = 1'b1;
        #1;
        chk("ind_accept_ready", 32'(grp_ready), 32'h1);
        chk("ind_accept_iss", 32'(iss_mask), 32'h0);
        tick();
        grp_valid = 1'b0;
        #1;
        chk("ind_iss", 32'(iss_mask), 32'hF);
        chk("ind_ready", 32'(grp_ready), 32'h1);
        chk("ind_des", 32'(iss_des), 32'h4321);
        tick();
        chk("ind_stall", 32'(stall_cycles), 32'h0);
        idle(4);

        // Intra-group RAW
        slot(0, 4'd1, 4'd5, 4'd6);   slot(1, 4'd7, 4'd1, 4'd8);
        slot(2, 4'd9, 4'd10, 4'd11); slot(3, 4'd12, 4'd13, 4'd14);
        ins_valid = 4'b1111; grp_valid = 1'b1;
        #1;
        chk("raw_accept_ready", 32'(grp_ready), 32'h1);
        tick();
        grp_valid = 1'b0;
        #1;
        chk("raw_c0_iss", 32'(iss_mask), 32'h1);
        chk("raw_c0_ready", 32'(grp_ready), 32'h0);
        tick(); #1;
        chk("raw_c1_busy_r1", 32'(dut.busy_q[1]), 32'h3);
        chk("raw_c1_iss", 32'(iss_mask), 32'h0);
        tick(); #1;
        chk("raw_c2_iss", 32'(iss_mask), 32'h0);
        tick(); #1;
        chk("raw_c3_iss", 32'(iss_mask), 32'h0);
        tick(); #1;
        chk("raw_c4_iss", 32'(iss_mask), 32'hE);
        chk("raw_c4_ready", 32'(grp_ready), 32'h1);
        tick();
        chk("raw_stall", 32'(stall_cycles), 32'h3);
        idle(4);

        // WAR then WAW on r6
        slot(0, 4'd2, 4'd3, 4'd6); slot(1, 4'd6, 4'd4, 4'd5);
        slot(2, 4'd6, 4'd4, 4'd5); slot(3, 4'd8, 4'd9, 4'd10);
        ins_valid = 4'b1111; grp_valid = 1'b1;
        tick();
        grp_valid = 1'b0;
        #1;
        chk("war_c0_iss", 32'(iss_mask), 32'h1);
        tick(); #1;
        chk("waw_c1_iss", 32'(iss_mask), 32'h2);
        tick(); #1;
        chk("waw_c2_iss", 32'(iss_mask), 32'h0);
        tick(); tick(); tick(); #1;
        chk("waw_c5_iss", 32'(iss_mask), 32'hC);
        tick();
        chk("waw_stall", 32'(stall_cycles), 32'h6);
        idle(4);

        // Sparse group, then an all-invalid group
        slot(0, 4'd1, 4'd5, 4'd6);  slot(1, 4'd2, 4'd7, 4'd8);
        slot(2, 4'd3, 4'd9, 4'd10); slot(3, 4'd4, 4'd11, 4'd12);
        ins_valid = 4'b1010; grp_valid = 1'b1;
        tick();
        ins_valid = 4'b0000;
        #1;
        chk("sparse_iss", 32'(iss_mask), 32'hA);
        chk("sparse_ready", 32'(grp_ready), 32'h1);
        tick();
        grp_valid = 1'b0;
        #1;
        chk("empty_iss", 32'(iss_mask), 32'h0);
        chk("empty_ready", 32'(grp_ready), 32'h1);
        tick();
        chk("empty_stall", 32'(stall_cycles), 32'h6);
        idle(4);

        // Flush mid-group
        slot(0, 4'd2, 4'd5, 4'd6);  slot(1, 4'd3, 4'd7, 4'd8);
        slot(2, 4'd9, 4'd2, 4'd10); slot(3, 4'd11, 4'd12, 4'd13);
        ins_valid = 4'b1111; grp_valid = 1'b1;
        tick();
        grp_valid = 1'b0;
        #1;
        chk("fl_c0_iss", 32'(iss_mask), 32'h3);
        tick(); #1;
        chk("fl_c1_pending", 32'(dut.pending_q), 32'hC);
        tick();
        slot(0, 4'd1, 4'd2, 4'd5);  slot(1, 4'd4, 4'd2, 4'd6);
        slot(2, 4'd7, 4'd10, 4'd11); slot(3, 4'd8, 4'd12, 4'd13);
        ins_valid = 4'b1111; grp_valid = 1'b1; flush = 1'b1;
        #1;
        chk("fl_c2_busy_r2", 32'(dut.busy_q[2]), 32'h2);
        chk("fl_c2_iss", 32'(iss_mask), 32'h0);
        chk("fl_c2_ready", 32'(grp_ready), 32'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("fl_c3_pending", 32'(dut.pending_q), 32'h0);
        chk("fl_c3_busy_r2", 32'(dut.busy_q[2]), 32'h0);
        chk("fl_c3_ready", 32'(grp_ready), 32'h1);
        tick();
        grp_valid = 1'b0;
        #1;
        chk("fl_c4_iss", 32'(iss_mask), 32'hF);
        tick();
        idle(4);

        // Async reset with a partially issued group
        slot(0, 4'd5, 4'd6, 4'd7);   slot(1, 4'd9, 4'd5, 4'd10);
        slot(2, 4'd11, 4'd13, 4'd14); slot(3, 4'd12, 4'd0, 4'd15);
        ins_valid = 4'b1111; grp_valid = 1'b1;
        tick();
        grp_valid = 1'b0;
        #1;
        chk("ar_c0_iss", 32'(iss_mask), 32'h1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("ar_iss", 32'(iss_mask), 32'h0);
        chk("ar_ready", 32'(grp_ready), 32'h0);
        chk("ar_stall", 32'(stall_cycles), 32'h0);
        chk("ar_pending", 32'(dut.pending_q), 32'h0);
        chk("ar_busy_r5", 32'(dut.busy_q[5]), 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("ar_release_ready", 32'(grp_ready), 32'h1);
        chk("ar_release_iss", 32'(iss_mask), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
